// File: rtl/fpu_arb_pkg.sv
// fpu_arb_pkg: shared state type and adder status/timing constants for fpu_arbiter.
package fpu_arb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CAPTURE} fpu_arb_state_t;
  localparam logic [3:0] FPU_ST_EXACT     = 4'b0001;
  localparam logic [3:0] FPU_ST_INEXACT   = 4'b0010;
  localparam logic [3:0] FPU_ST_OVERFLOW  = 4'b0100;
  localparam logic [3:0] FPU_ST_UNDERFLOW = 4'b1000;
  localparam int FPU_MIN_WAIT = 38;
endpackage

// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester-side request/response bus of the shared fpu arbiter.
interface fpu_arbiter_if #(parameter int N_REQ = 4);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_op_a;
  logic [N_REQ*32-1:0] req_op_b;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [31:0]         rsp_data;
  logic [3:0]          rsp_status;
  modport master (output req_valid, req_op_a, req_op_b,
                  input req_ready, rsp_valid, rsp_id, rsp_data, rsp_status);
  modport slave (input req_valid, req_op_a, req_op_b,
                 output req_ready, rsp_valid, rsp_id, rsp_data, rsp_status);
endinterface

// File: rtl/fpu_arbiter_rr_pick.sv
// rr_pick: combinational winner select, round-robin after last, or lowest index
// when FPU_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
`ifndef FPU_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0]    last,
`endif
  output logic [IW-1:0]    idx,
  output logic             any
);
  assign any = |req;
`ifdef FPU_ARB_FIXED_PRIO_EN
  always_comb begin
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[k]) idx = IW'(k);
  end
`else
  // Scan from farthest to nearest so the slot right after last wins.
  always_comb begin
    idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(last) + k) % N_REQ]) idx = IW'((int'(last) + k) % N_REQ);
  end
`endif
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: shares one handshake-less fpu adder among N_REQ requesters by owning its reset.
// Define FPU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WAIT_CYCLES = 40
) (
  input  logic          clk,
  input  logic          reset,
  fpu_arbiter_if.slave  bus,
  output logic [31:0]   fpu_op_a,
  output logic [31:0]   fpu_op_b,
  output logic          fpu_rst_n,
  input  logic [31:0]   fpu_data,
  input  logic [3:0]    fpu_status
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(WAIT_CYCLES);
  fpu_arb_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [IW-1:0] grant;
  logic [IW-1:0] win;
  logic          any;
`ifdef FPU_ARB_FIXED_PRIO_EN
  rr_pick #(.N_REQ(N_REQ)) u_pick (.req(bus.req_valid), .idx(win), .any(any));
`else
  logic [IW-1:0] last_grant;
  rr_pick #(.N_REQ(N_REQ)) u_pick (.req(bus.req_valid), .last(last_grant), .idx(win), .any(any));
`endif
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && any) ? RUN :
              (state == RUN && cnt == CW'(WAIT_CYCLES - 1)) ? CAPTURE :
              (state == CAPTURE) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // The adder leaves reset on the grant edge, so it steps exactly WAIT_CYCLES times before capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      grant          <= '0;
`ifndef FPU_ARB_FIXED_PRIO_EN
      last_grant     <= IW'(N_REQ - 1);
`endif
      fpu_op_a       <= '0;
      fpu_op_b       <= '0;
      fpu_rst_n      <= 1'b0;
      bus.req_ready  <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_status <= '0;
    end else begin
      bus.req_ready <= '0;
      bus.rsp_valid <= 1'b0;
      if (state == IDLE && any) begin
        fpu_op_a      <= bus.req_op_a[32*win +: 32];
        fpu_op_b      <= bus.req_op_b[32*win +: 32];
        grant         <= win;
`ifndef FPU_ARB_FIXED_PRIO_EN
        last_grant    <= win;
`endif
        bus.req_ready <= N_REQ'(1) << win;
        fpu_rst_n     <= 1'b1;
        cnt           <= '0;
      end
      if (state == RUN) cnt <= cnt + 1'b1;
      if (state == CAPTURE) begin
        bus.rsp_data   <= fpu_data;
        bus.rsp_status <= fpu_status;
        bus.rsp_id     <= grant;
        bus.rsp_valid  <= 1'b1;
        fpu_rst_n      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: randomized and directed checks of fpu_arbiter against a cycle-count
// reference model, with a table-driven stand-in for the fpu adder.
module tb_fpu_arbiter;
  import fpu_arb_pkg::*;
  localparam int N  = 4;
  localparam int W  = 40;
  localparam int NT = 6;
  localparam logic [31:0] TA [NT] = '{32'h3F800000, 32'h7F7FFFFF, 32'h00000000,
                                      32'h3F800000, 32'h3F800000, 32'h40400000};
  localparam logic [31:0] TB [NT] = '{32'h40000000, 32'h7F7FFFFF, 32'h00000000,
                                      32'h3F800000, 32'h33800000, 32'hBF800000};
  localparam logic [31:0] TS [NT] = '{32'h40400000, 32'h7F800000, 32'h00000000,
                                      32'h40000000, 32'h3F800000, 32'h40000000};
  localparam logic [3:0] TST [NT] = '{FPU_ST_EXACT, FPU_ST_OVERFLOW, FPU_ST_EXACT,
                                      FPU_ST_EXACT, FPU_ST_INEXACT, FPU_ST_EXACT};
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data;
  logic        fpu_rst_n;
  logic [3:0]  fpu_status;
  always #5 clk = ~clk;
  fpu_arbiter_if #(.N_REQ(N)) bus ();
  fpu_arbiter #(.N_REQ(N), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b), .fpu_rst_n(fpu_rst_n),
    .fpu_data(fpu_data), .fpu_status(fpu_status)
  );
  // Adder stand-in: garbage until it has run its worst-case pass length out of reset.
  int fsteps;
  always @(posedge clk or negedge fpu_rst_n)
    if (!fpu_rst_n) fsteps <= 0;
    else fsteps <= fsteps + 1;
  always_comb begin
    fpu_data = 32'hFFFF_FFFF;
    fpu_status = 4'b0000;
    if (fsteps >= FPU_MIN_WAIT)
      for (int i = 0; i < NT; i++)
        if (fpu_op_a == TA[i] && fpu_op_b == TB[i]) begin
          fpu_data = TS[i];
          fpu_status = TST[i];
        end
  end
  int tests = 0, fails = 0;
  int cyc = 0, next_free = 0, last = N - 1, due = -1, gcyc = -1, exp_id = 0, exp_e = 0;
  int op_e [N];
  bit rereq_en = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  function automatic int pick(input logic [N-1:0] v);
`ifdef FPU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction
  task automatic set_req(input int i, input int e);
    op_e[i] = e;
    bus.req_op_a[32*i +: 32] = TA[e];
    bus.req_op_b[32*i +: 32] = TB[e];
    bus.req_valid[i] = 1'b1;
  endtask
  // One clock edge: predict grant/response from elapsed cycles, then compare after the edge.
  task automatic step();
    int w;
    logic [N-1:0] er;
    @(posedge clk);
    er = '0;
    w = (cyc >= next_free) ? pick(bus.req_valid) : -1;
    if (w >= 0) begin
      er[w] = 1'b1;
      last = w;
      gcyc = cyc;
      due = cyc + W + 1;
      next_free = cyc + W + 2;
      exp_id = w;
      exp_e = op_e[w];
    end
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(cyc == due));
    chk("fpu_rst_n", 32'(fpu_rst_n), 32'(gcyc >= 0 && cyc >= gcyc && cyc < due));
    if (w >= 0) begin
      chk("fpu_op_a", fpu_op_a, TA[exp_e]);
      chk("fpu_op_b", fpu_op_b, TB[exp_e]);
    end
    if (cyc == due) begin
      chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
      chk("rsp_data", bus.rsp_data, TS[exp_e]);
      chk("rsp_status", 32'(bus.rsp_status), 32'(TST[exp_e]));
    end
    for (int i = 0; i < N; i++)
      if (er[i]) begin
        if (rereq_en && $urandom_range(0, 1) == 1) set_req(i, int'($urandom_range(0, NT - 1)));
        else bus.req_valid[i] = 1'b0;
      end
    cyc++;
  endtask
  task automatic reset_pulse();
    reset = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_status", 32'(bus.rsp_status), 32'h0);
    chk("rst_fpu_op_a", fpu_op_a, 32'h0);
    chk("rst_fpu_op_b", fpu_op_b, 32'h0);
    chk("rst_fpu_rst_n", 32'(fpu_rst_n), 32'h0);
    repeat (3) @(posedge clk);
    cyc += 3;
    #2 reset = 1'b1;
    last = N - 1;
    due = -1;
    gcyc = -1;
    next_free = cyc;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_op_a = '0;
    bus.req_op_b = '0;
    reset_pulse();
    for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, NT - 1)));
    repeat (4 * (W + 2) + 2) step();
    set_req(2, 0);
    repeat (W + 3) step();
    set_req(0, 1);
    repeat (W + 3) step();
    set_req(3, 2);
    repeat (W + 3) step();
    set_req(0, 3);
    repeat (11) step();
    set_req(1, 4);
    repeat (2 * (W + 2) + 2) step();
    set_req(1, 5);
    repeat (21) step();
    reset_pulse();
    repeat (4) step();
    set_req(2, 0);
    repeat (W + 3) step();
    rereq_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 15) == 0) set_req(i, int'($urandom_range(0, NT - 1)));
      step();
    end
    rereq_en = 1'b0;
    repeat (W + 3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
